divider_8by4: RTL and testbench

- Sequential restoring divider: 8-bit dividend ÷ 4-bit divisor gives an 8-bit quotient and a 4-bit remainder.
- It is the inverse datapath of the 4x4 array multiplier: dividend = quotient*divisor + remainder, for any divisor != 0 whose quotient fits.
- Resolves one quotient bit per clock and uses a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic unit, built from the same gate-level adder cells.

---
 rtl/divider_8by4_pkg.sv | 23 ++
 rtl/divider_sub_step.sv | 38 +++
 rtl/divider_8by4.sv | 123 ++++++++++++
 tb/tb_divider_8by4.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/divider_8by4_pkg.sv
// ============================================================================
// Module : divider_8by4_pkg
// Brief  : Shared state encoding and width constants for the 8/4 divider.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package divider_8by4_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int REM_W      = 5;
  localparam int ITER_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/divider_sub_step.sv
// ============================================================================
// Module : divider_sub_step
// Brief  : One restoring-division step: trial subtract R' - divisor through a
//          ripple of full-adder cells; carry-out is the quotient bit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_sub_step
  import divider_8by4_pkg::*;
(
  input  logic [REM_W-1:0]     r_prime,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [REM_W-1:0]     r_next,
  output logic                 q_bit
);

  logic [REM_W-1:0] b_inv;
  logic [REM_W-1:0] diff;
  logic [REM_W:0]   carry;

  // Subtraction as R' + ~divisor + 1; no borrow (carry-out 1) means R' >= divisor.
  assign b_inv    = ~{1'b0, divisor};
  assign carry[0] = 1'b1;

  generate
    for (genvar i = 0; i < REM_W; i++) begin : g_fa
      assign diff[i]    = r_prime[i] ^ b_inv[i] ^ carry[i];
      assign carry[i+1] = (r_prime[i] & b_inv[i]) | (carry[i] & (r_prime[i] ^ b_inv[i]));
    end
  endgenerate

  assign q_bit  = carry[REM_W];
  assign r_next = q_bit ? diff : r_prime;

endmodule

`default_nettype wire

// File: rtl/divider_8by4.sv
// ============================================================================
// Module : divider_8by4
// Brief  : Sequential restoring divider, 8-bit / 4-bit, one quotient bit per
//          clock with start/busy/done handshake. Optional macro
//          DIVIDER_ZERO_DETECT_EN adds the dz port and a 1-edge zero path.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_8by4
  import divider_8by4_pkg::*;
#(
  parameter int N_ITER = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
`ifdef DIVIDER_ZERO_DETECT_EN
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  dz
`else
  output logic [DIVISOR_W-1:0]  remainder
`endif
);

  localparam logic [ITER_CNT_W-1:0] LAST_ITER = ITER_CNT_W'(N_ITER - 1);

  state_t                  state;
  logic [DIVIDEND_W-1:0]   shreg;
  logic [DIVISOR_W-1:0]    dvsr;
  logic [REM_W-1:0]        rem;
  logic [ITER_CNT_W-1:0]   cnt;

  logic [REM_W-1:0]        r_prime;
  logic [REM_W-1:0]        r_next;
  logic                    q_bit;
  logic                    zero_fast;

  // shreg shifts dividend bits out of the MSB while quotient bits enter at the LSB.
  assign r_prime = {rem[DIVISOR_W-1:0], shreg[DIVIDEND_W-1]};

`ifdef DIVIDER_ZERO_DETECT_EN
  assign zero_fast = (divisor == '0);
`else
  assign zero_fast = 1'b0;
`endif

  divider_sub_step u_sub_step (
    .r_prime (r_prime),
    .divisor (dvsr),
    .r_next  (r_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      shreg     <= '0;
      dvsr      <= '0;
      rem       <= '0;
      cnt       <= '0;
`ifdef DIVIDER_ZERO_DETECT_EN
      dz        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (zero_fast) begin
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= dividend[DIVISOR_W-1:0];
            end else begin
              state <= CALC;
              busy  <= 1'b1;
              shreg <= dividend;
              dvsr  <= divisor;
              rem   <= '0;
              cnt   <= '0;
            end
`ifdef DIVIDER_ZERO_DETECT_EN
            dz <= zero_fast;
`endif
          end
        end
        CALC: begin
          shreg <= {shreg[DIVIDEND_W-2:0], q_bit};
          rem   <= r_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= {shreg[DIVIDEND_W-2:0], q_bit};
            remainder <= r_next[DIVISOR_W-1:0];
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_divider_8by4.sv
// ============================================================================
// Module : tb_divider_8by4
// Brief  : Randomised self-checking bench for divider_8by4 against an
//          arithmetic reference (/ and %).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divider_8by4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
`ifdef DIVIDER_ZERO_DETECT_EN
  logic       dz;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] prev_q = 8'h00;
  logic [3:0] prev_r = 4'h0;

  divider_8by4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
`ifdef DIVIDER_ZERO_DETECT_EN
    .remainder (remainder),
    .dz        (dz)
`else
    .remainder (remainder)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_q(input logic [7:0] dd, input logic [3:0] dv);
    return (dv == 0) ? 8'hFF : 8'(int'(dd) / int'(dv));
  endfunction

  function automatic logic [3:0] ref_r(input logic [7:0] dd, input logic [3:0] dv);
    return (dv == 0) ? dd[3:0] : 4'(int'(dd) % int'(dv));
  endfunction

  task automatic do_op(input logic [7:0] dd, input logic [3:0] dv);
    int lat = 0;
    int bcnt = 0;
    int exp_lat = 9;
    int exp_busy = 8;
    logic [7:0] eq;
    logic [3:0] er;
    eq = ref_q(dd, dv);
    er = ref_r(dd, dv);
`ifdef DIVIDER_ZERO_DETECT_EN
    if (dv == 0) begin
      exp_lat  = 1;
      exp_busy = 0;
    end
`endif
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 1 && !done) begin
        check("hold_q", quotient, prev_q);
        check("hold_r", remainder, prev_r);
      end
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    check("latency", lat, exp_lat);
    check("busy_cycles", bcnt, exp_busy);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
`ifdef DIVIDER_ZERO_DETECT_EN
    check("dz", dz, (dv == 0) ? 1 : 0);
`endif
    @(negedge clk);
    check("done_pulse", done, 0);
    check("q_after", quotient, eq);
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    int dcount;
    logic [7:0] rd;
    logic [3:0] rv;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(8'd200, 4'd7);
    do_op(8'd255, 4'd15);
    do_op(8'd0,   4'd5);
    do_op(8'd100, 4'd1);
    do_op(8'd9,   4'd12);
    do_op(8'd13,  4'd0);

    // Start pulsed mid-calculation must be ignored.
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    dcount = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 4) begin
        dividend = 8'd99; divisor = 4'd3; start = 1'b1;
      end
      if (done) begin
        dcount++;
        check("ign_q", quotient, 28);
        check("ign_r", remainder, 4);
      end
    end
    check("ign_done_cnt", dcount, 1);
    prev_q = 8'd28; prev_r = 4'd4;

    // Asynchronous reset mid-operation.
    dividend = 8'd150; divisor = 4'd11; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_q", quotient, 0);
    check("arst_r", remainder, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("arst_no_done", dcount, 0);
    prev_q = 8'h00; prev_r = 4'h0;
    do_op(8'd77, 4'd6);

    // Back-to-back with start held high through DONE.
    dividend = 8'd150; divisor = 4'd11; start = 1'b1;
    dcount = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        dcount = 1;
        break;
      end
    end
    check("b2b_first_done", dcount, 1);
    check("b2b_q1", quotient, 13);
    check("b2b_r1", remainder, 7);
    dividend = 8'd77; divisor = 4'd6;
    @(negedge clk);
    check("b2b_idle_busy", busy, 0);
    check("b2b_idle_q", quotient, 13);
    @(negedge clk);
    check("b2b_accept_busy", busy, 1);
    check("b2b_hold_q", quotient, 13);
    start = 1'b0;
    dcount = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        dcount = 1;
        break;
      end
    end
    check("b2b_second_done", dcount, 1);
    check("b2b_q2", quotient, 12);
    check("b2b_r2", remainder, 5);
    prev_q = 8'd12; prev_r = 4'd5;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      rd = 8'($urandom_range(0, 255));
      rv = (i % 8 == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      do_op(rd, rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
